// File: rtl/ej32_pkg.sv
// eJ32 shared definitions: memory map constants and the OBUF drain FSM states.
// Imported by obuf_drain, dict_setup and the testbench.
package ej32_pkg;

  localparam int unsigned ASZ_DEF   = 17;
  localparam int unsigned OBUF_BASE = 'h1400;
  localparam int unsigned OBUF_SIZE = 'h600;

  typedef enum logic [2:0] {
    dIDLE,
    dREQ,
    dRD,
    dWAIT,
    dSEND,
    dDONE
  } drain_st_t;

endpackage

// File: rtl/obuf_drain.sv
// OBUF drain: reads the output buffer over the byte bus and streams it
// onto a valid/ready channel, releasing the bus while the sink stalls.
module obuf_drain
  import ej32_pkg::*;
#(
  parameter int unsigned ASZ  = ASZ_DEF,
  parameter int unsigned OBUF = OBUF_BASE,
  parameter int unsigned OBSZ = OBUF_SIZE
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] len,
  output logic           bus_req,
  input  logic           bus_gnt,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_re,
  input  logic [7:0]     mem_d,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy,
  output logic           done
);

  localparam logic [ASZ-1:0] BASE = ASZ'(OBUF);
  localparam logic [ASZ-1:0] SIZE = ASZ'(OBSZ);
  localparam logic [ASZ-1:0] LAST = ASZ'(OBSZ - 1);
  localparam logic [ASZ-1:0] ONE  = ASZ'(1);

  drain_st_t      st;
  logic [ASZ-1:0] idx;
  logic [ASZ-1:0] cnt;
  logic           rd_q;

  // A grant lost during RD must not leave a read strobe on the bus.
  assign mem_re = rd_q & bus_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= dIDLE;
      idx      <= '0;
      cnt      <= '0;
      rd_q     <= 1'b0;
      bus_req  <= 1'b0;
      mem_a    <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        dIDLE: begin
          if (start) begin
            idx  <= '0;
            busy <= 1'b1;
            if (len == '0) begin
              cnt  <= '0;
              st   <= dDONE;
              done <= 1'b1;
            end else begin
              cnt     <= (len > SIZE) ? SIZE : len;
              st      <= dREQ;
              bus_req <= 1'b1;
            end
          end
        end
        dREQ: begin
          if (bus_gnt) begin
            st    <= dRD;
            rd_q  <= 1'b1;
            mem_a <= BASE + idx;
          end
        end
        dRD: begin
          rd_q  <= 1'b0;
          mem_a <= '0;
          if (!bus_gnt) begin
            st <= dREQ;
          end else begin
            st      <= dWAIT;
            bus_req <= 1'b0;
          end
        end
        dWAIT: begin
          tx_data  <= mem_d;
          tx_valid <= 1'b1;
          st       <= dSEND;
        end
        dSEND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            cnt      <= cnt - ONE;
            idx      <= (idx == LAST) ? '0 : idx + ONE;
            if (cnt == ONE) begin
              st   <= dDONE;
              done <= 1'b1;
            end else begin
              st      <= dREQ;
              bus_req <= 1'b1;
            end
          end
        end
        dDONE: begin
          st   <= dIDLE;
          busy <= 1'b0;
        end
        default: st <= dIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obuf_drain.sv
// Directed-random bench for obuf_drain with a byte-array memory model
// and an expected stream computed from the buffer contents.
module tb_obuf_drain;
  import ej32_pkg::*;

  localparam int ASZ = 17;
  localparam int OB  = OBUF_BASE;
  localparam int OS  = OBUF_SIZE;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [ASZ-1:0] len;
  logic           bus_req;
  logic           bus_gnt;
  logic [ASZ-1:0] mem_a;
  logic           mem_re;
  logic [7:0]     mem_d;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic           done;

  obuf_drain dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mem_a(mem_a), .mem_re(mem_re), .mem_d(mem_d),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<ASZ)-1];

  always @(posedge clk) begin
    if (mem_re) mem_d <= mem[mem_a];
  end

  byte unsigned rx[$];
  int unsigned  addrs[$];
  int checks = 0;
  int errors = 0;
  int bad_req_send, bad_re, bad_hold, req_seen, done_cnt;
  logic       hold_q;
  logic [7:0] hold_d;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    if (mem_re) addrs.push_back(int'(mem_a));
    if (tx_valid && bus_req) bad_req_send++;
    if (mem_re && !bus_gnt) bad_re++;
    if (bus_req) req_seen++;
    if (done) done_cnt++;
    if (hold_q && (!tx_valid || tx_data !== hold_d)) bad_hold++;
    hold_q = tx_valid && !tx_ready;
    hold_d = tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rx.delete();
    addrs.delete();
    bad_req_send = 0;
    bad_re = 0;
    bad_hold = 0;
    req_seen = 0;
    done_cnt = 0;
    hold_q = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one drain and apply the stall/grant-drop policy each cycle.
  // cyc counts cycles after the start edge until done is seen.
  task automatic run(input int n, input int stall_at, input bit gdrop,
                     output int cyc);
    int  stalled = 0;
    int  gd = 0;
    bit  dropped = 0;
    start = 1'b1;
    len = ASZ'(n);
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 4*OS + 64) begin
      if (stall_at >= 0 && rx.size() == stall_at && tx_valid && stalled < 5) begin
        tx_ready = 1'b0;
        stalled++;
      end else begin
        tx_ready = 1'b1;
      end
      if (gdrop && !dropped && mem_re) begin
        dropped = 1;
        gd = 3;
      end
      if (gd > 0) begin
        bus_gnt = 1'b0;
        gd--;
      end else begin
        bus_gnt = 1'b1;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    bus_gnt = 1'b1;
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_stream(input string tag, input int n);
    int nexp = (n > OS) ? OS : n;
    chk({tag, "_count"}, rx.size(), nexp);
    for (int i = 0; i < nexp && i < rx.size(); i++)
      chk({tag, "_byte"}, rx[i], mem[OB + (i % OS)]);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bus_req"}, {31'd0, bus_req}, 0);
    chk({tag, "_mem_re"}, {31'd0, mem_re}, 0);
    chk({tag, "_mem_a"}, 32'(mem_a), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
  endtask

  initial begin
    int cyc;
    int c;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    bus_gnt = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < OS; i++) mem[OB + i] = 8'($urandom);
    mem[OB + 0] = 8'h6f;
    mem[OB + 1] = 8'h6b;
    mem[OB + 2] = 8'h0a;
    clr();
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // "ok\n" with immediate grant and ready
    clr();
    run(3, -1, 0, cyc);
    chk("t1_cycles", cyc, 13);
    chk_stream("t1", 3);
    chk("t1_b0", rx.size() > 0 ? rx[0] : 0, 8'h6f);
    chk("t1_req_in_send", bad_req_send, 0);
    tick();
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_after", {31'd0, busy}, 0);

    // zero length
    clr();
    run(0, -1, 0, cyc);
    chk("t2_cycles", cyc, 1);
    chk("t2_busy_in_done", {31'd0, busy}, 1);
    tick();
    chk("t2_busy_after", {31'd0, busy}, 0);
    chk("t2_done_after", {31'd0, done}, 0);
    chk("t2_req_seen", req_seen, 0);
    chk("t2_rx", rx.size(), 0);

    // sink stalls five cycles on the second byte
    for (int i = 0; i < OS; i++) mem[OB + i] = 8'($urandom);
    mem[OB + 1] = 8'h6b;
    clr();
    run(3, 1, 0, cyc);
    chk("t3_cycles", cyc, 18);
    chk_stream("t3", 3);
    chk("t3_hold", bad_hold, 0);
    chk("t3_req_in_send", bad_req_send, 0);
    tick();

    // grant lost during the first read
    clr();
    run(4, -1, 1, cyc);
    chk("t4_cycles", cyc, 21);
    chk("t4_re_no_gnt", bad_re, 0);
    chk("t4_reads", addrs.size(), 4);
    for (int i = 0; i < 4 && i < addrs.size(); i++)
      chk("t4_addr", addrs[i], OB + i);
    chk_stream("t4", 4);
    tick();

    // oversize length is clamped to the buffer size
    clr();
    run(OS + 4, -1, 0, cyc);
    chk("t5_cycles", cyc, 4*OS + 1);
    chk("t5_reads", addrs.size(), OS);
    chk("t5_first", addrs.size() > 0 ? addrs[0] : 0, OB);
    chk("t5_last", addrs.size() > 0 ? addrs[addrs.size()-1] : 0, OB + OS - 1);
    chk_stream("t5", OS + 4);
    tick();

    // reset while the second byte is pending in SEND
    clr();
    start = 1'b1;
    len = ASZ'(3);
    tick();
    start = 1'b0;
    c = 0;
    while (!(rx.size() == 1 && tx_valid) && c < 100) begin
      tx_ready = (rx.size() == 1) ? 1'b0 : 1'b1;
      tick();
      c++;
    end
    chk("t6_pending", {31'd0, tx_valid}, 1);
    tick();
    rst = 1'b1;
    tick();
    chk_idle_outputs("t6_rst");
    rst = 1'b0;
    tx_ready = 1'b1;
    tick();
    tick();
    chk("t6_no_done", done_cnt, 0);
    clr();
    run(2, -1, 0, cyc);
    chk("t6_cycles", cyc, 9);
    chk("t6_first_addr", addrs.size() > 0 ? addrs[0] : 0, OB);
    chk_stream("t6", 2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
